// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8-bit, LSB-first, one-stop-bit serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (11-bit frames).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_byte,
    output logic                          tx_ready,
    output logic                          tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int DIV_W    = $clog2(BAUD_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BAUD_DIV - 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head_byte;

    assign tx_ready   = (fifo_count != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (fifo_count == '0);
    assign head_byte  = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked by fifo_count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_byte;
    end

    // ---------------------------------------------------------------- serialiser
    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             tx_data_next;
    logic             div_last;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit, parity_next;
`endif

    assign div_last = (div_cnt == DIV_LAST);
    assign busy     = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_data <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            tx_data <= tx_data_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        div_next   = (state == S_IDLE || div_last) ? '0 : div_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = head_byte;
                    state_next = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^head_byte;
`endif
                end
            end
            S_START: begin
                if (div_last) begin
                    state_next = S_DATA;
                    bit_next   = '0;
                end
            end
            S_DATA: begin
                if (div_last) begin
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (div_last) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                // Chaining straight into START keeps back-to-back frames gap-free.
                if (div_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = head_byte;
                        state_next = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^head_byte;
`endif
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // The line level is registered from the state being entered, so it has no input-to-output path.
        case (state_next)
            S_START: tx_data_next = 1'b0;
            S_DATA:  tx_data_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_data_next = parity_next;
`endif
            default: tx_data_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model compared every cycle,
// a mid-bit line decoder, and literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DEPTH     = 8;
    localparam int BD        = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
    localparam logic [10:0] EXP41 = 11'b10010000010;
`else
    localparam int FL = 10;
    localparam logic [9:0] EXP41 = 10'b1010000010;
`endif
    localparam int FRAME = FL * BD;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       tx_data;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered bytes, and the frame on the line as a bit vector plus a clock position.
    logic [7:0]    q_m[$];
    bit            m_active = 0;
    int            m_pos    = 0;
    logic [FL-1:0] m_frame;

    function automatic logic [FL-1:0] make_frame(input logic [7:0] b);
        logic [FL-1:0] f;
        f       = '1;
        f[0]    = 1'b0;
        f[8:1]  = b;
`ifdef UART_TX_PARITY_EN
        f[9]    = ^b;
`endif
        return f;
    endfunction

    task automatic model_step();
        bit push, pop;
        if (reset) begin
            q_m.delete();
            m_active = 0;
            m_pos    = 0;
            return;
        end
        push = tx_valid && (q_m.size() != DEPTH);
        pop  = (q_m.size() != 0) && (!m_active || m_pos == FRAME - 1);
        if (m_active && !pop) begin
            if (m_pos == FRAME - 1) m_active = 0;
            else                    m_pos++;
        end
        if (pop) begin
            m_frame  = make_frame(q_m.pop_front());
            m_active = 1;
            m_pos    = 0;
        end
        if (push) q_m.push_back(tx_byte);
    endtask

    task automatic compare();
        logic exp_line;
        exp_line = m_active ? m_frame[m_pos / BD] : 1'b1;
        check("tx_data",    tx_data,    exp_line);
        check("fifo_count", fifo_count, q_m.size());
        check("busy",       busy,       m_active || q_m.size() != 0);
        check("tx_ready",   tx_ready,   q_m.size() != DEPTH);
    endtask

    // Independent line decoder sampling each bit at its midpoint.
    bit            dec_active = 0;
    int            dec_cnt    = 0;
    logic [FL-1:0] dec_bits;
    logic [7:0]    dec_q[$];
    logic          dec_par_q[$];

    task automatic decode();
        int idx;
        if (dec_active) begin
            dec_cnt++;
            if (dec_cnt % BD == BD / 2) begin
                idx = dec_cnt / BD;
                dec_bits[idx] = tx_data;
                if (idx == FL - 1) begin
                    dec_q.push_back(dec_bits[8:1]);
                    check("stop_bit", dec_bits[FL-1], 1'b1);
`ifdef UART_TX_PARITY_EN
                    dec_par_q.push_back(dec_bits[9]);
                    check("parity_even", dec_bits[9], ^dec_bits[8:1]);
`endif
                    dec_active = 0;
                end
            end
        end else if (tx_data === 1'b0) begin
            dec_active = 1;
            dec_cnt    = 0;
            dec_bits[0] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        if (reset) dec_active = 0;
        @(negedge clk);
        compare();
        decode();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((busy !== 1'b0 || m_active || q_m.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", n < max_cycles, 1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_byte  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    initial begin
        int            drop;
        logic          line_log[200];
        logic [FL-1:0] exp41;
        bit            ready_seen_low;
        bit            line_stayed_high;
        int            n;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        tick();
        tick();
        check("rst_tx_data", tx_data, 1'b1);
        check("rst_count",   fifo_count, 0);
        check("rst_busy",    busy, 1'b0);
        check("rst_ready",   tx_ready, 1'b1);
        reset = 1'b0;
        tick();

        // Single byte 0x41: line falls one cycle after acceptance, mid-bit samples, busy drop time.
        send(8'h41);
        check("accept_count", fifo_count, 1);
        tick();
        check("start_latency", tx_data, 1'b0);
        check("pop_count", fifo_count, 0);
        drop = -1;
        line_log[0] = tx_data;
        for (int t = 1; t < 200; t++) begin
            tick();
            line_log[t] = tx_data;
            if (busy === 1'b0 && drop < 0) drop = t;
        end
        exp41 = EXP41;
        for (int b = 0; b < FL; b++) check("mid_bit_0x41", line_log[b * BD + 8], exp41[b]);
        check("busy_drop", drop, FRAME);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 carries parity 1, 0x03 carries parity 0.
        dec_q.delete();
        dec_par_q.delete();
        send(8'h07);
        send(8'h03);
        wait_idle(3 * FRAME);
        check("par_frames", dec_par_q.size(), 2);
        if (dec_par_q.size() == 2) begin
            check("par_0x07", dec_par_q[0], 1'b1);
            check("par_0x03", dec_par_q[1], 1'b0);
        end
`endif

        // Nine bytes on consecutive cycles from idle.
        dec_q.delete();
        ready_seen_low = 0;
        for (int i = 0; i < 9; i++) begin
            if (tx_ready !== 1'b1) ready_seen_low = 1;
            send(8'h10 + 8'(i));
        end
        check("nine_ready_high", ready_seen_low, 1'b0);
        check("nine_count", fifo_count, 8);
        wait_idle(10 * FRAME);
        check("nine_decoded", dec_q.size(), 9);
        for (int i = 0; i < 9 && i < dec_q.size(); i++) check("nine_order", dec_q[i], 8'h10 + 8'(i));

        // Fill while a frame is in progress; a write when full is dropped.
        dec_q.delete();
        send(8'hA0);
        repeat (20) tick();
        for (int i = 1; i <= 8; i++) send(8'hA0 + 8'(i));
        check("full_ready", tx_ready, 1'b0);
        check("full_count", fifo_count, 8);
        send(8'hEE);
        check("drop_count", fifo_count, 8);
        wait_idle(10 * FRAME);
        check("fill_decoded", dec_q.size(), 9);
        for (int i = 0; i < 9 && i < dec_q.size(); i++) check("fill_no_ee", dec_q[i], 8'hA0 + 8'(i));

        // Reset mid-DATA of 0x5A with three bytes queued.
        send(8'h5A);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        repeat (40) tick();
        reset = 1'b1;
        tick();
        check("abort_tx_data", tx_data, 1'b1);
        check("abort_count",   fifo_count, 0);
        check("abort_busy",    busy, 1'b0);
        check("abort_ready",   tx_ready, 1'b1);
        reset = 1'b0;
        line_stayed_high = 1;
        for (int t = 0; t < 500; t++) begin
            tick();
            if (tx_data !== 1'b1) line_stayed_high = 0;
        end
        check("abort_line_high", line_stayed_high, 1'b1);

        // Push coinciding with the STOP pop while two bytes are buffered.
        send(8'h31);
        send(8'h32);
        send(8'h33);
        check("pp_count_before", fifo_count, 2);
        n = 0;
        while (!(m_active && m_pos == FRAME - 1) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("pp_reach_stop", n < 2 * FRAME, 1'b1);
        send(8'h34);
        check("pp_count_after", fifo_count, 2);
        check("pp_next_start",  tx_data, 1'b0);
        wait_idle(5 * FRAME);

        // Randomised traffic with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            tx_valid = ($urandom_range(0, 99) < 10);
            tx_byte  = 8'($urandom);
            reset    = ($urandom_range(0, 999) == 0);
            tick();
        end
        tx_valid = 1'b0;
        reset    = 1'b0;
        wait_idle(10 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
